// File: rtl/mem_responder_pkg.sv
// Shared constants and FSM encoding for the memory responder.
package mem_responder_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;
  localparam int WS_MAX = 15;
  localparam int CNT_W  = $clog2(WS_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;
endpackage

// File: rtl/mem_responder_if.sv
// Request/ack bus between a requester (master) and the memory responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = mem_responder_pkg::ADDR_W,
  parameter int DATA_W = mem_responder_pkg::DATA_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              err;

  modport master (output req, we, addr, wdata, input rdata, ack, busy, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM, write-first, contents not reset.
module mem_array #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 12,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures one request, waits WAIT_STATES cycles, commits and acks.
module mem_responder #(
  parameter int ADDR_W      = mem_responder_pkg::ADDR_W,
  parameter int DATA_W      = mem_responder_pkg::DATA_W,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 2
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);
  import mem_responder_pkg::*;

  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] WS_LD = CNT_W'(WAIT_STATES);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q;
  req_t              req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_q, err_q, rd_live_q;
  logic [DATA_W-1:0] rdata_q;

  logic              go_ack, in_rng, ram_en;
  req_t              cur;
  logic [DATA_W-1:0] ram_rdata;

  // With zero wait states the RAM access happens on the acceptance edge, so it
  // must see the live bus rather than the not-yet-captured request.
  assign cur    = (state_q == IDLE) ? {bus.we, bus.addr, bus.wdata} : req_q;
  assign go_ack = ((state_q == IDLE) && bus.req && (WAIT_STATES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
  assign in_rng = 32'(cur.addr) < DEPTH;
  assign ram_en = go_ack && in_rng;

  mem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(MAW)) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur.we),
    .addr  (cur.addr[MAW-1:0]),
    .wdata (cur.wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_live_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_live_q <= 1'b0;
      // RAM output is live during ACK; latch it so later writes cannot disturb it.
      if (rd_live_q) rdata_q <= ram_rdata;
      if (go_ack) begin
        ack_q     <= 1'b1;
        err_q     <= !in_rng;
        rd_live_q <= !cur.we && in_rng;
        if (!cur.we && !in_rng) rdata_q <= '0;
      end
      case (state_q)
        IDLE: if (bus.req) begin
          req_q   <= cur;
          cnt_q   <= WS_LD;
          state_q <= (WAIT_STATES == 0) ? ACK : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdata = rd_live_q ? ram_rdata : rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three configurations, scoreboard of expected acks.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if b2 ();
  mem_responder_if b0 ();
  mem_responder_if bd ();

  mem_responder #(.DEPTH(4096), .WAIT_STATES(2)) u_ws2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  mem_responder #(.DEPTH(4096), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_d1k (.clk(clk), .rst_n(rst_n), .bus(bd));

  typedef struct packed {
    logic [11:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;
  } out_t;

  typedef struct {
    logic [11:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [11:0] mdl[int];
  logic [11:0] last[3];
  int tests = 0;
  int fails = 0;

  function automatic int ws(int k);   return (k == 1) ? 0 : 2;       endfunction
  function automatic int dep(int k);  return (k == 2) ? 1024 : 4096; endfunction

  function automatic out_t get(int k);
    out_t o;
    case (k)
      0:       o = {b2.rdata, b2.ack, b2.busy, b2.err};
      1:       o = {b0.rdata, b0.ack, b0.busy, b0.err};
      2:       o = {bd.rdata, bd.ack, bd.busy, bd.err};
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic drv(int k, logic r, logic w, logic [11:0] a, logic [11:0] d);
    case (k)
      0:       begin b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d; end
      1:       begin b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d; end
      2:       begin bd.req = r; bd.we = w; bd.addr = a; bd.wdata = d; end
      default: ;
    endcase
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response for one request, derived from the bench memory model.
  function automatic exp_t predict(int k, logic w, logic [11:0] a, logic [11:0] d);
    exp_t e;
    int   key = k * 4096 + int'(a);
    logic inr = int'(a) < dep(k);
    e.err = !inr;
    if (w) begin
      if (inr) mdl[key] = d;
      e.rdata = last[k];
    end else begin
      e.rdata = inr ? mdl[key] : 12'h000;
      last[k] = e.rdata;
    end
    return e;
  endfunction

  task automatic xact(int k, logic w, logic [11:0] a, logic [11:0] d, string tag);
    exp_t e;
    out_t o;
    int   n;
    sbq.push_back(predict(k, w, a, d));
    drv(k, 1'b1, w, a, d);
    @(posedge clk); #1;
    drv(k, 1'b0, 1'bx, 12'bx, 12'bx);
    n = 0;
    forever begin
      o = get(k);
      if (o.ack === 1'b1 || n > 20) break;
      chk({tag, ".busy_wait"}, 32'(o.busy), 32'd1);
      @(posedge clk); #1;
      n++;
    end
    e = sbq.pop_front();
    chk({tag, ".latency"}, n, ws(k));
    chk({tag, ".busy_ack"}, 32'(o.busy), 32'd1);
    chk({tag, ".rdata"}, 32'(o.rdata), 32'(e.rdata));
    chk({tag, ".err"}, 32'(o.err), 32'(e.err));
    @(posedge clk); #1;
    o = get(k);
    chk({tag, ".ack_drop"}, 32'(o.ack), 32'd0);
    chk({tag, ".busy_drop"}, 32'(o.busy), 32'd0);
    chk({tag, ".rdata_hold"}, 32'(o.rdata), 32'(e.rdata));
  endtask

  task automatic chk_reset(string tag);
    out_t o;
    for (int k = 0; k < 3; k++) begin
      o = get(k);
      chk($sformatf("%s.%0d.rdata", tag, k), 32'(o.rdata), 32'd0);
      chk($sformatf("%s.%0d.ack", tag, k), 32'(o.ack), 32'd0);
      chk($sformatf("%s.%0d.busy", tag, k), 32'(o.busy), 32'd0);
      chk($sformatf("%s.%0d.err", tag, k), 32'(o.err), 32'd0);
      last[k] = 12'h000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    out_t o;
    exp_t e;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) drv(k, 1'b0, 1'bx, 12'bx, 12'bx);
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_init");
    rst_n = 1'b1;

    // Basic write/read with two wait states.
    xact(0, 1'b1, 12'o0200, 12'o7402, "wr0200");
    xact(0, 1'b0, 12'o0200, 12'o0000, "rd0200");

    // req held high with a new address every cycle: only IDLE samples count.
    for (int i = 0; i < 12; i++) xact(0, 1'b1, 12'(12'o0400 + i), 12'(12'o1100 + 3 * i), "pre_ign");
    for (int i = 0; i < 12; i++) begin
      drv(0, 1'b1, 1'b0, 12'(12'o0400 + i), 12'o7777);
      if (i % 4 == 0) sbq.push_back(predict(0, 1'b0, 12'(12'o0400 + i), 12'o0000));
      @(posedge clk); #1;
      o = get(0);
      chk($sformatf("ign.ack%0d", i), 32'(o.ack), 32'(i % 4 == 2));
      if (o.ack === 1'b1 && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk($sformatf("ign.rdata%0d", i), 32'(o.rdata), 32'(e.rdata));
      end
    end
    drv(0, 1'b0, 1'bx, 12'bx, 12'bx);
    @(posedge clk); #1;
    chk("ign.sb_empty", sbq.size(), 0);

    // Zero wait states: ack right after acceptance, back-to-back every 2 cycles.
    for (int i = 0; i < 4; i++) xact(1, 1'b1, 12'(i), 12'(12'o6543 - 12'o101 * i), "ws0_wr");
    xact(1, 1'b0, 12'o0000, 12'o0000, "ws0_rd0000");
    for (int i = 0; i < 6; i++) begin
      drv(1, 1'b1, 1'b0, 12'(i % 4), 12'o0000);
      if (i % 2 == 0) sbq.push_back(predict(1, 1'b0, 12'(i % 4), 12'o0000));
      @(posedge clk); #1;
      o = get(1);
      chk($sformatf("b2b.ack%0d", i), 32'(o.ack), 32'(i % 2 == 0));
      if (o.ack === 1'b1 && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk($sformatf("b2b.rdata%0d", i), 32'(o.rdata), 32'(e.rdata));
      end
    end
    drv(1, 1'b0, 1'bx, 12'bx, 12'bx);
    @(posedge clk); #1;
    chk("b2b.sb_empty", sbq.size(), 0);

    // Reset while a write sits in WAIT: the write must never land.
    xact(0, 1'b1, 12'o0100, 12'o0017, "wr0100_old");
    drv(0, 1'b1, 1'b1, 12'o0100, 12'o1234);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'bx, 12'bx, 12'bx);
    o = get(0);
    chk("rst_mid.in_wait", 32'(o.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("reset_async");
    repeat (3) @(posedge clk);
    #1 chk_reset("reset_held");
    rst_n = 1'b1;
    xact(0, 1'b0, 12'o0100, 12'o0000, "rd0100_after_rst");

    // Partial depth: out-of-range accesses flag err and never touch memory.
    xact(2, 1'b1, 12'o1000, 12'o2222, "d1k_wr1000");
    xact(2, 1'b1, 12'o1777, 12'o4321, "d1k_wr1777");
    xact(2, 1'b0, 12'o1777, 12'o0000, "d1k_rd1777a");
    xact(2, 1'b1, 12'o3000, 12'o5555, "d1k_wr3000_oor");
    xact(2, 1'b0, 12'o3000, 12'o0000, "d1k_rd3000_oor");
    xact(2, 1'b0, 12'o1000, 12'o0000, "d1k_rd1000_alias");
    xact(2, 1'b0, 12'o1777, 12'o0000, "d1k_rd1777b");

    chk("final.sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
